// File: rtl/circ_smpl_queue.sv
// Circular sample queue: decimates incoming samples into a DEPTH-entry RAM and,
// once WINDOW samples are held, streams the latest WINDOW samples oldest-first.
module circ_smpl_queue #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int WINDOW     = 1021,
  parameter int DECIM      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] new_smpl,
  input  logic              wrt_smpl,
  output logic [DATA_W-1:0] smpl_out,
  output logic              smpl_vld,
  output logic              first_smpl,
  output logic              last_smpl,
  output logic              sequencing,
  output logic              full,
  output logic              overrun
);
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int FILL_W = $clog2(WINDOW + 1);
  localparam int CNT_W  = $clog2(WINDOW);

  localparam logic [DEC_W-1:0]      DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [FILL_W-1:0]     FILL_MAX = FILL_W'(WINDOW);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [DEPTH_LOG2-1:0] WIN_A    = DEPTH_LOG2'(WINDOW);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_nxt;
  logic [FILL_W-1:0]     fill, fill_nxt;
  logic [DEC_W-1:0]      dec_cnt;
  logic [CNT_W-1:0]      rd_cnt;
  logic                  accept, start;

  assign accept   = wrt_smpl && (dec_cnt == DEC_LAST);
  assign wr_nxt   = wr_ptr + DEPTH_LOG2'(1);
  assign fill_nxt = (fill == FILL_MAX) ? fill : fill + FILL_W'(1);
  assign start    = accept && (state == IDLE) && (fill_nxt == FILL_MAX);
  assign full     = (fill == FILL_MAX);

  // RAM has no reset; its contents are irrelevant until refilled
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= new_smpl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      dec_cnt    <= '0;
      rd_cnt     <= '0;
      smpl_out   <= '0;
      smpl_vld   <= 1'b0;
      first_smpl <= 1'b0;
      last_smpl  <= 1'b0;
      sequencing <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wrt_smpl) dec_cnt <= accept ? '0 : dec_cnt + DEC_W'(1);
      // Writes proceed even mid-burst; the write slot is always outside the window
      if (accept) begin
        wr_ptr <= wr_nxt;
        fill   <= fill_nxt;
        if (state != IDLE) overrun <= 1'b1;
      end
      smpl_vld   <= (state == READ);
      first_smpl <= (state == READ) && (rd_cnt == '0);
      last_smpl  <= (state == READ) && (rd_cnt == CNT_LAST);
      if (state == READ) smpl_out <= mem[rd_ptr];
      case (state)
        IDLE: if (start) begin
          state      <= READ;
          rd_ptr     <= wr_nxt - WIN_A;
          rd_cnt     <= '0;
          sequencing <= 1'b1;
        end
        READ: begin
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
          rd_cnt <= rd_cnt + CNT_W'(1);
          if (rd_cnt == CNT_LAST) state <= DRAIN;
        end
        DRAIN: begin
          state      <= IDLE;
          sequencing <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_circ_smpl_queue.sv
// Directed bench for circ_smpl_queue: three configurations share one stimulus
// path, selected by sel; a small history model supplies expected bursts.
module tb_circ_smpl_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] new_smpl = '0;
  logic        wrt = 1'b0;
  int          sel = 0;

  logic [15:0] so [3];
  logic [2:0]  vl, fs, ls, sq, fl, ov;

  always #5 clk = ~clk;

  circ_smpl_queue #(.DATA_W(16), .DEPTH_LOG2(3), .WINDOW(5), .DECIM(2)) u_a (
    .clk(clk), .rst(rst), .new_smpl(new_smpl), .wrt_smpl(wrt && sel == 0),
    .smpl_out(so[0]), .smpl_vld(vl[0]), .first_smpl(fs[0]), .last_smpl(ls[0]),
    .sequencing(sq[0]), .full(fl[0]), .overrun(ov[0]));

  circ_smpl_queue #(.DATA_W(16), .DEPTH_LOG2(3), .WINDOW(5), .DECIM(1)) u_b (
    .clk(clk), .rst(rst), .new_smpl(new_smpl), .wrt_smpl(wrt && sel == 1),
    .smpl_out(so[1]), .smpl_vld(vl[1]), .first_smpl(fs[1]), .last_smpl(ls[1]),
    .sequencing(sq[1]), .full(fl[1]), .overrun(ov[1]));

  circ_smpl_queue u_c (
    .clk(clk), .rst(rst), .new_smpl(new_smpl), .wrt_smpl(wrt && sel == 2),
    .smpl_out(so[2]), .smpl_vld(vl[2]), .first_smpl(fs[2]), .last_smpl(ls[2]),
    .sequencing(sq[2]), .full(fl[2]), .overrun(ov[2]));

  int          n_chk = 0, n_err = 0;
  int          W, D, dec, fill;
  logic        exp_ovr;
  logic [15:0] hist [$];
  logic [15:0] win [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int w, input int d);
    W = w; D = d; dec = 0; fill = 0; exp_ovr = 1'b0;
    hist.delete();
  endtask

  function automatic void snap();
    win.delete();
    for (int i = hist.size() - W; i < hist.size(); i++) win.push_back(hist[i]);
  endfunction

  // one strobe; returns at the negedge of the cycle after the accept edge
  task automatic send(input logic [15:0] v, output bit burst);
    bit acc;
    @(negedge clk); new_smpl = v; wrt = 1'b1;
    @(negedge clk); wrt = 1'b0;
    acc   = (dec == D - 1);
    dec   = acc ? 0 : dec + 1;
    burst = 1'b0;
    if (acc) begin
      hist.push_back(v);
      if (fill < W) fill++;
      burst = (fill == W);
    end
  endtask

  task automatic expect_burst(input string tag, input bit started);
    if (!started) begin
      chk($sformatf("%s seq@T+1", tag), sq[sel], 1);
      chk($sformatf("%s vld@T+1", tag), vl[sel], 0);
      @(negedge clk);
    end
    for (int k = 0; k < W; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("%s data[%0d]", tag, k), so[sel], win[k]);
      chk($sformatf("%s vld[%0d]", tag, k), vl[sel], 1);
      chk($sformatf("%s first[%0d]", tag, k), fs[sel], k == 0);
      chk($sformatf("%s last[%0d]", tag, k), ls[sel], k == W - 1);
      chk($sformatf("%s seq[%0d]", tag, k), sq[sel], 1);
    end
    @(negedge clk);
    chk($sformatf("%s seq end", tag), sq[sel], 0);
    chk($sformatf("%s vld end", tag), vl[sel], 0);
    chk($sformatf("%s hold", tag), so[sel], win[W-1]);
  endtask

  task automatic step(input logic [15:0] v, input string tag, input int gap);
    bit b;
    send(v, b);
    chk($sformatf("%s full v%0d", tag, v), fl[sel], fill == W);
    chk($sformatf("%s ovr v%0d", tag, v), ov[sel], exp_ovr);
    if (b) begin
      snap();
      expect_burst($sformatf("%s v%0d", tag, v), 1'b0);
    end else begin
      chk($sformatf("%s noburst v%0d", tag, v), sq[sel], 0);
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    bit b;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst smpl_out", so[0], 0);
    chk("rst vld", vl[0], 0);
    chk("rst seq", sq[0], 0);
    chk("rst full", fl[0], 0);
    chk("rst ovr", ov[0], 0);
    rst = 1'b0;

    // fill, first burst, slide and pointer wrap (depth 8, window 5, decim 2)
    sel = 0; model_reset(5, 2);
    for (int v = 1; v <= 30; v++) step(16'(v), "fill", 2);

    // overrun: back-to-back accepts, second arrives mid-burst
    sel = 1; model_reset(5, 1);
    for (int v = 95; v <= 99; v++) step(16'(v), "pre", 3);
    @(negedge clk); new_smpl = 16'd100; wrt = 1'b1;
    @(negedge clk); new_smpl = 16'd101;
    hist.push_back(16'd100); snap(); hist.push_back(16'd101);
    @(negedge clk); wrt = 1'b0;
    chk("ovr set", ov[1], 1);
    expect_burst("ovr burst", 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("ovr no queued burst", sq[1], 0);
    end
    exp_ovr = 1'b1;
    step(16'd102, "post ovr", 3);

    // asynchronous reset at the third valid cycle of a burst
    send(16'd103, b);
    chk("rstb started", b, 1);
    snap();
    chk("rstb seq", sq[1], 1);
    repeat (3) @(negedge clk);
    chk("rstb vld3", vl[1], 1);
    chk("rstb data3", so[1], win[2]);
    #1 rst = 1'b1;
    #1;
    chk("rstb smpl_out", so[1], 0);
    chk("rstb vld", vl[1], 0);
    chk("rstb first", fs[1], 0);
    chk("rstb last", ls[1], 0);
    chk("rstb seq", sq[1], 0);
    chk("rstb full", fl[1], 0);
    chk("rstb ovr", ov[1], 0);
    @(negedge clk); rst = 1'b0;
    model_reset(5, 1);
    for (int v = 200; v <= 204; v++) step(16'(v), "after rst", 3);

    // default configuration, first 1021-sample burst
    sel = 2; model_reset(1021, 2);
    for (int v = 1; v <= 2042; v++) step(16'(v), "def", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
